// File: rtl/adder_time_param.sv
// Loadable up/down modulo counter with configurable step, enable prescaler and carry/borrow pulse.
// Latency: q, carry and tick all update on the clk edge of the tick cycle (no added latency vs en).
// Backpressure: none; en is a plain enable, cascade stages by feeding carry into the next en.
//
// Ports:
//   clk    rising-edge clock
//   clr    asynchronous active-low reset (clears q, carry, tick, prescaler)
//   load   synchronous load of in (clamped to MAX_VAL); wins over en
//   en     count enable, divided by DIV through the prescaler
//   up     direction (1 = up, 0 = down), sampled on the tick cycle
//   in     load value
//   q      registered count value
//   carry  one-cycle pulse on wrap (up) / borrow (down), or on clamping
//   tick   one-cycle pulse on each prescaled count event
//
// Build option: define ADDER_TIME_SAT_EN to saturate at 0 / MAX_VAL instead of wrapping.

module adder_time_param #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 2**WIDTH - 1,
    parameter int STEP    = 1,
    parameter int DIV     = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             tick
);

    // Prescaler needs at least one bit even when DIV == 1 (it then stays 0).
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] L_PRE_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] L_PRE_ONE  = PW'(1);

    // Arithmetic is one bit wider than the count so MAX_VAL = 2**WIDTH-1 cannot overflow silently.
    localparam logic [WIDTH:0] L_MAX  = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH:0] L_STEP = (WIDTH + 1)'(STEP);
`ifndef ADDER_TIME_SAT_EN
    localparam logic [WIDTH:0] L_MOD  = (WIDTH + 1)'(MAX_VAL + 1);
`endif

    logic [WIDTH-1:0] r_q;
    logic [PW-1:0]    r_pre;
    logic             r_carry;
    logic             r_tick;

    logic [WIDTH:0]   w_q_ext;
    logic [WIDTH:0]   w_in_ext;
    logic [WIDTH:0]   w_sum;
    logic             w_up_ovf;
    logic             w_dn_unf;
    logic [WIDTH-1:0] w_up_res;
    logic [WIDTH-1:0] w_dn_res;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_limit;
    logic [WIDTH-1:0] w_load_val;
    logic             w_tick;

    assign w_q_ext  = {1'b0, r_q};
    assign w_in_ext = {1'b0, in};

    // A tick fires on the DIV-th enabled cycle since the last tick/load/reset.
    assign w_tick   = en & (r_pre == L_PRE_LAST);

    assign w_sum    = w_q_ext + L_STEP;
    assign w_up_ovf = (w_sum > L_MAX);
    assign w_dn_unf = (w_q_ext < L_STEP);

`ifdef ADDER_TIME_SAT_EN
    // Clamp at the limits; carry flags every clamped tick, even when already at the limit.
    assign w_up_res = w_up_ovf ? L_MAX[WIDTH-1:0] : w_sum[WIDTH-1:0];
    assign w_dn_res = w_dn_unf ? '0 : WIDTH'(w_q_ext - L_STEP);
`else
    // Modular wrap: fold the excess back by one modulus in either direction.
    assign w_up_res = w_up_ovf ? WIDTH'(w_sum - L_MOD) : w_sum[WIDTH-1:0];
    assign w_dn_res = w_dn_unf ? WIDTH'(w_q_ext + L_MOD - L_STEP) : WIDTH'(w_q_ext - L_STEP);
`endif

    assign w_cnt_nxt  = up ? w_up_res : w_dn_res;
    assign w_limit    = up ? w_up_ovf : w_dn_unf;

    // Out-of-range load values are clamped so q never leaves 0..MAX_VAL.
    assign w_load_val = (w_in_ext > L_MAX) ? L_MAX[WIDTH-1:0] : in;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_q     <= '0;
            r_pre   <= '0;
            r_carry <= 1'b0;
            r_tick  <= 1'b0;
        end else if (load) begin
            r_q     <= w_load_val;
            r_pre   <= '0;
            r_carry <= 1'b0;
            r_tick  <= 1'b0;
        end else if (en) begin
            if (w_tick) begin
                r_q     <= w_cnt_nxt;
                r_pre   <= '0;
                r_carry <= w_limit;
                r_tick  <= 1'b1;
            end else begin
                r_pre   <= r_pre + L_PRE_ONE;
                r_carry <= 1'b0;
                r_tick  <= 1'b0;
            end
        end else begin
            // Prescaler phase is preserved while en is low.
            r_carry <= 1'b0;
            r_tick  <= 1'b0;
        end
    end

    assign q     = r_q;
    assign carry = r_carry;
    assign tick  = r_tick;

endmodule

// File: tb/tb_adder_time_param.sv
// Scoreboard bench for adder_time_param: four instances with different MAX_VAL/STEP/DIV share stimulus.
// Expected {q,carry,tick} per instance is queued at drive time and checked one edge later by a monitor.
// No flow control; every cycle is driven and every cycle produces one expectation.

module tb_adder_time_param;

    logic       clk = 1'b0;
    logic       clr;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] din;

    logic [3:0] q0, q1, q2, q3;
    logic       c0, c1, c2, c3;
    logic       t0, t1, t2, t3;

    always #5 clk = ~clk;

    // Instance configurations (index 0..3).
    int p_max  [4] = '{9, 9, 9, 15};
    int p_step [4] = '{1, 3, 1, 5};
    int p_div  [4] = '{1, 1, 3, 2};

    adder_time_param #(.WIDTH(4), .MAX_VAL(9),  .STEP(1), .DIV(1)) u_a (
        .clk(clk), .clr(clr), .load(load), .en(en), .up(up), .in(din), .q(q0), .carry(c0), .tick(t0));
    adder_time_param #(.WIDTH(4), .MAX_VAL(9),  .STEP(3), .DIV(1)) u_b (
        .clk(clk), .clr(clr), .load(load), .en(en), .up(up), .in(din), .q(q1), .carry(c1), .tick(t1));
    adder_time_param #(.WIDTH(4), .MAX_VAL(9),  .STEP(1), .DIV(3)) u_c (
        .clk(clk), .clr(clr), .load(load), .en(en), .up(up), .in(din), .q(q2), .carry(c2), .tick(t2));
    adder_time_param #(.WIDTH(4), .MAX_VAL(15), .STEP(5), .DIV(2)) u_d (
        .clk(clk), .clr(clr), .load(load), .en(en), .up(up), .in(din), .q(q3), .carry(c3), .tick(t3));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: count value and number of enabled cycles since the last tick.
    int m_q   [4] = '{0, 0, 0, 0};
    int m_ens [4] = '{0, 0, 0, 0};

    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [5:0] act_of(input int i);
        case (i)
            0:       return {q0, c0, t0};
            1:       return {q1, c1, t1};
            2:       return {q2, c2, t2};
            default: return {q3, c3, t3};
        endcase
    endfunction

    task automatic model_step(input logic c, input logic l, input logic e, input logic u,
                              input logic [3:0] d, output logic [23:0] ex);
        int  md;
        logic mc, mt;
        ex = '0;
        for (int i = 0; i < 4; i++) begin
            md = p_max[i] + 1;
            mc = 1'b0;
            mt = 1'b0;
            if (!c) begin
                m_q[i]   = 0;
                m_ens[i] = 0;
            end else if (l) begin
                m_q[i]   = (int'(d) > p_max[i]) ? p_max[i] : int'(d);
                m_ens[i] = 0;
            end else if (e) begin
                m_ens[i]++;
                if (m_ens[i] == p_div[i]) begin
                    m_ens[i] = 0;
                    mt = 1'b1;
                    if (u) begin
                        mc = (m_q[i] + p_step[i] > p_max[i]);
`ifdef ADDER_TIME_SAT_EN
                        m_q[i] = mc ? p_max[i] : m_q[i] + p_step[i];
`else
                        m_q[i] = (m_q[i] + p_step[i]) % md;
`endif
                    end else begin
                        mc = (m_q[i] < p_step[i]);
`ifdef ADDER_TIME_SAT_EN
                        m_q[i] = mc ? 0 : m_q[i] - p_step[i];
`else
                        m_q[i] = (m_q[i] - p_step[i] + md) % md;
`endif
                    end
                end
            end
            ex[i*6 +: 6] = {4'(m_q[i]), mc, mt};
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce.
    task automatic drive(input logic c, input logic l, input logic e, input logic u, input logic [3:0] d);
        logic [23:0] ex;
        @(negedge clk);
        clr  = c;
        load = l;
        en   = e;
        up   = u;
        din  = d;
        model_step(c, l, e, u, d, ex);
        exp_q.push_back(ex);
        if (!c) begin
            // Reset must act before any clock edge.
            #1;
            check("async_clr_a", {q0, c0, t0}, 6'd0);
            check("async_clr_bcd", {q1, c1, t1, q2, c2, t2, q3, c3, t3}, 18'd0);
        end
    endtask

    // Wait until just after the next rising edge for a directed spot check.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle with a pending expectation is compared per instance.
    initial begin
        logic [23:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < 4; i++)
                    check($sformatf("sb_inst%0d_qct", i), 32'(act_of(i)), 32'(e[i*6 +: 6]));
            end
        end
    end

    initial begin
        clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; din = 4'd0;
        #1;
        check("reset_state", {q0, c0, t0, q3, c3, t3}, 12'd0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        // Count up to 5, then async clear between edges (and once mid-load).
        repeat (5) drive(1, 0, 1, 1, 0);
        settle();
        check("count_to_5", q0, 4'd5);
        drive(0, 0, 1, 1, 0);
        drive(0, 1, 1, 1, 7);

        // Ten up ticks from 0: wraps to 0 with carry on the last one.
        repeat (10) drive(1, 0, 1, 1, 0);
        settle();
        check("wrap_up_q_c_t", {q0, c0, t0}, {4'd0, 1'b1, 1'b1});

        // Load wins over en; out-of-range load clamps.
        drive(1, 1, 1, 1, 7);
        settle();
        check("load7", {q0, c0, t0}, {4'd7, 1'b0, 1'b0});
        drive(1, 1, 1, 1, 12);
        settle();
        check("load12_clamp", q0, 4'd9);
        check("load12_max15", q3, 4'd12);

        // Down from 1: step 1 -> 0 then borrow to 9; step 3 -> borrow to 8.
        drive(1, 1, 0, 0, 1);
        drive(1, 0, 1, 0, 0);
        settle();
        check("down_1to0", {q0, c0}, {4'd0, 1'b0});
        check("down_step3_borrow", {q1, c1}, {4'd8, 1'b1});
        drive(1, 0, 1, 0, 0);
        settle();
        check("down_0to9", {q0, c0}, {4'd9, 1'b1});

        // Prescale by 3: increments on clocks 3, 6, 9; phase survives en gaps.
        drive(1, 1, 0, 0, 0);
        repeat (9) drive(1, 0, 1, 1, 0);
        settle();
        check("div3_after9", {q2, t2}, {4'd3, 1'b1});
        drive(1, 0, 1, 1, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 1, 1, 0);
        settle();
        check("div3_phase_hold", {q2, t2}, {4'd3, 1'b0});
        drive(1, 0, 1, 1, 0);
        settle();
        check("div3_phase_tick", {q2, t2}, {4'd4, 1'b1});

        // Limit behaviour at the top and bottom.
        drive(1, 1, 0, 1, 9);
        drive(1, 0, 1, 1, 0);
        settle();
`ifdef ADDER_TIME_SAT_EN
        check("sat_up_1", {q0, c0}, {4'd9, 1'b1});
        drive(1, 0, 1, 1, 0);
        settle();
        check("sat_up_2", {q0, c0}, {4'd9, 1'b1});
`else
        check("wrap_9to0", {q0, c0}, {4'd0, 1'b1});
        drive(1, 0, 1, 1, 0);
        settle();
        check("wrap_0to1", {q0, c0}, {4'd1, 1'b0});
`endif
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        settle();
`ifdef ADDER_TIME_SAT_EN
        check("sat_down", {q0, c0}, {4'd0, 1'b1});
`else
        check("wrap_down_0to9", {q0, c0}, {4'd9, 1'b1});
`endif

        // Randomised traffic against the reference model.
        repeat (400) begin
            drive(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom),
                  4'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
